fsm_table_engine: RTL
=====================

Name: fsm_table_engine

Overview:
- Parametrised, run-time programmable Moore state machine.
- Next-state and output tables live in internal registers and are written over a config port. One generic block replaces hand-coded small FSMs such as sequence detectors and mode controllers.
- Adds clock enable, soft clear, illegal-state recovery and a per-state dwell timeout.
- Sits between the input conditioning logic and downstream control.

Parameters:
- STATE_W, 3, state register width.
- NUM_STATES, 7, legal states 0..NUM_STATES-1; must be ≤ 2**STATE_W.
- IN_W, 1, input symbol width; each state has 2**IN_W table entries.
- OUT_W, 1, Moore output width.
- RESET_STATE, 0, state entered on reset, soft clear, illegal state or timeout.
- CNT_W, 8, dwell counter width.
- TIMEOUT, 0, dwell limit in cycles; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  advance the FSM this cycle
- sync_clr  in  1  synchronous return to RESET_STATE
- x  in  IN_W  input symbol, sampled when en=1
- cfg_ns_we  in  1  write next-state entry
- cfg_out_we  in  1  write output entry
- cfg_state  in  STATE_W  table row (source state)
- cfg_in  in  IN_W  table column (input symbol); used by cfg_ns_we only
- cfg_ns  in  STATE_W  next-state data
- cfg_out  in  OUT_W  output data
- state_o  out  STATE_W  current state
- out_sig  out  OUT_W  registered Moore output
- dwell_o  out  CNT_W  cycles spent in current state, saturating
- timeout_p  out  1  one-cycle pulse on a timeout transition
- illegal_err  out  1  sticky flag: illegal state entered or illegal table target
- cfg_err  out  1  one-cycle pulse when a config write is rejected

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state_o=RESET_STATE, out_sig=0, dwell_o=0, timeout_p=0, illegal_err=0, cfg_err=0.
  - All next-state entries = RESET_STATE; all output entries = 0.
- Priority per cycle: sync_clr > timeout > illegal-state recovery > normal transition.
- sync_clr=1:
  - state_o<=RESET_STATE, out_sig<=out_tbl[RESET_STATE], dwell_o<=0.
  - illegal_err cleared. Tables are kept.
- Normal transition (en=1):
  - ns = ns_tbl[state_o][x]; state_o<=ns; out_sig<=out_tbl[ns].
  - out_sig is therefore always aligned with state_o. Latency from x to state_o/out_sig is 1 cycle.
- en=0: state_o and out_sig hold. dwell_o still counts, because dwell measures clock cycles, not enabled steps.
- Dwell counter:
  - Clears to 0 on any change of state_o; otherwise increments.
  - Saturates at 2**CNT_W-1; no wrap-around.
  - A self-loop (ns==state_o) does not clear dwell.
- Timeout (TIMEOUT≠0 and dwell_o==TIMEOUT-1 at a clock edge):
  - state_o<=RESET_STATE regardless of en; timeout_p=1 for one cycle; dwell_o<=0.
  - If already in RESET_STATE, dwell_o is still cleared and timeout_p still pulses.
- Illegal state:
  - If state_o ≥ NUM_STATES, or a table lookup yields ns ≥ NUM_STATES, the next state is RESET_STATE and out_sig<=0.
  - illegal_err is set (sticky) and clears only on reset or sync_clr.
- Config writes:
  - Take effect at the clock edge.
  - A transition in the same cycle uses the pre-write table contents (read-before-write), including the out_tbl value latched into out_sig.
  - cfg_ns_we and cfg_out_we may be asserted together.
  - A write is rejected (no table change, cfg_err pulses) if cfg_state ≥ NUM_STATES or cfg_ns ≥ NUM_STATES. With both enables asserted, rejection applies to both writes.
- Config writes during reset (reset_n=0) are ignored.

Decomposition:
- Shared package fsm_pkg:
  - default widths;
  - RESET_STATE default;
  - the function computing the table index from state and input: {state, in}.
- Sub-module fsm_dwell_timer: saturating dwell counter plus timeout compare.
- Table storage and next-state logic stay in the top module.

Test Plan:
- Reset / default table: after reset with default parameters → state_o=0, out_sig=0. Any x with en=1 keeps state 0 and dwell counts 0,1,2…
- Programmed table: ns_tbl[0][0]=1, ns_tbl[0][1]=2, out_tbl[2]=1; x=1, en=1 → next cycle state_o=2, out_sig=1. Then en=0 for 5 cycles → state_o stays 2, dwell_o reaches 5.
- Timeout: TIMEOUT=4, state 3 self-looping → after 4 cycles in state 3, state_o=0, timeout_p high for exactly 1 cycle, dwell_o=0.
- Config rejection: cfg_ns_we with cfg_state=7 (NUM_STATES=7) → cfg_err pulses 1 cycle; a subsequent readback walk shows the table unchanged.
- Read-before-write: in state 1 with en=1, x=0, write ns_tbl[1][0]=5 in the same cycle (old value 3) → state_o=3. Returning to state 1 later with x=0 → state_o=5.
- Simultaneous sync_clr and timeout while in state 4 → state_o=0, timeout_p stays 0, illegal_err cleared. Asynchronous reset_n pulse mid-run → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared defaults, update-cause encoding and table addressing for the table-driven FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsm_pkg;

    localparam int DEF_STATE_W     = 3;
    localparam int DEF_NUM_STATES  = 7;
    localparam int DEF_IN_W        = 1;
    localparam int DEF_OUT_W       = 1;
    localparam int DEF_RESET_STATE = 0;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TIMEOUT     = 0;

    // Why the state register is updated this cycle, in priority order.
    typedef enum logic [2:0] {
        UPD_HOLD    = 3'd0,
        UPD_CLEAR   = 3'd1,
        UPD_TIMEOUT = 3'd2,
        UPD_RECOVER = 3'd3,
        UPD_STEP    = 3'd4
    } upd_e;

    // Flat next-state table index {state, in}: each state owns 2**in_w consecutive entries.
    function automatic int unsigned tbl_index(input int unsigned state,
                                              input int unsigned sym,
                                              input int unsigned in_w);
        return (state << in_w) | sym;
    endfunction

endpackage

// File: rtl/fsm_dwell_timer.sv
// Saturating count of cycles spent in the current state, with dwell-limit compare.
// Latency: count updates at each clock edge; timeout_hit is combinational from the count.
// Backpressure: none; counts every cycle regardless of the FSM clock enable.
module fsm_dwell_timer
    import fsm_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    output logic [CNT_W-1:0] dwell_o,
    output logic             timeout_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    // Limit reached on this edge; TIMEOUT of zero disables the compare entirely.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (dwell_o == TO_LAST);
    end

    // Restart on state change or timeout, otherwise count up and stick at the top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_o <= '0;
        end else if (clr || timeout_hit) begin
            dwell_o <= '0;
        end else if (dwell_o != CNT_MAX) begin
            dwell_o <= dwell_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fsm_table_engine.sv
// Run-time programmable Moore FSM: next-state/output tables written over a config port.
// Latency: 1 cycle from x (with en) to state_o/out_sig; config writes land at the same edge.
// Backpressure: none; en gates stepping, config writes are accepted or rejected in one cycle.
module fsm_table_engine
    import fsm_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int NUM_STATES  = DEF_NUM_STATES,
    parameter int IN_W        = DEF_IN_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int RESET_STATE = DEF_RESET_STATE,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [IN_W-1:0]    x,
    input  logic               cfg_ns_we,
    input  logic               cfg_out_we,
    input  logic [STATE_W-1:0] cfg_state,
    input  logic [IN_W-1:0]    cfg_in,
    input  logic [STATE_W-1:0] cfg_ns,
    input  logic [OUT_W-1:0]   cfg_out,
    output logic [STATE_W-1:0] state_o,
    output logic [OUT_W-1:0]   out_sig,
    output logic [CNT_W-1:0]   dwell_o,
    output logic               timeout_p,
    output logic               illegal_err,
    output logic               cfg_err
);

    localparam int ROWS  = 2 ** STATE_W;
    localparam int COLS  = 2 ** IN_W;
    localparam int IDX_W = STATE_W + IN_W;

    localparam logic [STATE_W:0]   NUM_S = (STATE_W + 1)'(NUM_STATES);
    localparam logic [STATE_W-1:0] RST_S = STATE_W'(RESET_STATE);

    // Tables span every encodable state so that any lookup stays in range;
    // rows at or above NUM_STATES are never written and keep their reset value.
    logic [STATE_W-1:0] ns_tbl  [ROWS*COLS];
    logic [OUT_W-1:0]   out_tbl [ROWS];

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [OUT_W-1:0]   out_d;
    upd_e               upd;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic [STATE_W-1:0] ns_lookup;
    logic               state_bad;
    logic               target_bad;
    logic               timeout_hit;
    logic               cfg_reject;

    assign state_o = state_q;

    // Table addressing and legality of the current state and its looked-up successor.
    always_comb begin
        rd_idx     = IDX_W'(tbl_index(32'(state_q), 32'(x), IN_W));
        wr_idx     = IDX_W'(tbl_index(32'(cfg_state), 32'(cfg_in), IN_W));
        ns_lookup  = ns_tbl[rd_idx];
        state_bad  = ({1'b0, state_q} >= NUM_S);
        target_bad = ({1'b0, ns_lookup} >= NUM_S);
        cfg_reject = (cfg_ns_we || cfg_out_we) &&
                     (({1'b0, cfg_state} >= NUM_S) || (cfg_ns_we && ({1'b0, cfg_ns} >= NUM_S)));
    end

    // Pick the update cause by priority, then the next state and its Moore output.
    // Reads use the current table contents, so a same-cycle config write is not seen.
    always_comb begin
        upd     = UPD_HOLD;
        state_d = state_q;
        out_d   = out_sig;
        if (sync_clr) begin
            upd = UPD_CLEAR;
        end else if (timeout_hit) begin
            upd = UPD_TIMEOUT;
        end else if (state_bad) begin
            upd = UPD_RECOVER;
        end else if (en) begin
            upd = target_bad ? UPD_RECOVER : UPD_STEP;
        end
        case (upd)
            UPD_CLEAR, UPD_TIMEOUT: begin
                state_d = RST_S;
                out_d   = out_tbl[RST_S];
            end
            UPD_RECOVER: begin
                state_d = RST_S;
                out_d   = '0;
            end
            UPD_STEP: begin
                state_d = ns_lookup;
                out_d   = out_tbl[ns_lookup];
            end
            default: begin
                state_d = state_q;
                out_d   = out_sig;
            end
        endcase
    end

    // State, aligned Moore output, timeout pulse and sticky illegal flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_S;
            out_sig     <= '0;
            timeout_p   <= 1'b0;
            illegal_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_sig     <= out_d;
            timeout_p   <= (upd == UPD_TIMEOUT);
            illegal_err <= (upd == UPD_CLEAR) ? 1'b0 : (illegal_err || (upd == UPD_RECOVER));
        end
    end

    // Table storage: legal writes land at the edge, illegal ones are dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ns_tbl  <= '{default: RST_S};
            out_tbl <= '{default: '0};
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_reject;
            if (!cfg_reject) begin
                if (cfg_ns_we) begin
                    ns_tbl[wr_idx] <= cfg_ns;
                end
                if (cfg_out_we) begin
                    out_tbl[cfg_state] <= cfg_out;
                end
            end
        end
    end

    fsm_dwell_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_dwell (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (sync_clr || (state_d != state_q)),
        .dwell_o     (dwell_o),
        .timeout_hit (timeout_hit)
    );

endmodule
